adc_in: RTL and testbench
=========================

ADC_IN -- requirements
Module: adc_in

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 24, bits per channel sample (valid range 2..32).
REQ-002 SHALL have port: BCLK  input  1  bit clock; all logic on posedge BCLK.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request capture of one stereo frame.
REQ-005 SHALL have port: continuous  input  1  when 1, the next frame starts back-to-back after each frame.
REQ-006 SHALL have port: ADCDAT  input  1  serial sample data from codec, MSB first.
REQ-007 SHALL have port: data_ack  input  1  consumer acknowledge of the held frame.
REQ-008 SHALL have port: ADCLRC  output  1  channel select, 0 = left, 1 = right.
REQ-009 SHALL have port: left_data  output  DATA_WIDTH  last completed left sample.
REQ-010 SHALL have port: right_data  output  DATA_WIDTH  last completed right sample.
REQ-011 SHALL have port: data_valid  output  1  held frame not yet acknowledged.
REQ-012 SHALL have port: busy  output  1  frame capture in progress.
REQ-013 SHALL have port: overrun  output  1  sticky; a frame was overwritten before acknowledge.

Function
REQ-014 SHALL implement FSM states IDLE, LEFT, RIGHT; all outputs registered.
REQ-015 SHALL, in IDLE with start=1, go to LEFT and clear bit counter and shift register; no ADCDAT sample on that edge.
REQ-016 SHALL ignore start while in LEFT or RIGHT.
REQ-017 SHALL, in LEFT, shift ADCDAT into the left shift register LSB-side each edge; after DATA_WIDTH samples go to RIGHT with counter cleared.
REQ-018 SHALL, in RIGHT, capture DATA_WIDTH bits the same way into the right shift register.
REQ-019 SHALL, on the edge taking the last right bit, commit both shift registers, including that bit, to left_data/right_data and set data_valid=1.
REQ-020 SHALL, after the commit, go to LEFT if continuous=1, else IDLE.
REQ-021 SHALL drive ADCLRC=1 only in RIGHT; busy=1 in LEFT or RIGHT.
REQ-022 SHALL give latency start edge E -> left bits sampled at edges E+1..E+W, right bits at E+W+1..E+2W, data_valid visible after E+2W (W=DATA_WIDTH).
REQ-023 SHALL clear data_valid on an edge with data_ack=1 and no commit on that edge.
REQ-024 SHALL, when commit and data_ack coincide, keep data_valid=1 with new data and leave overrun unchanged.
REQ-025 SHALL, on commit while data_valid=1 and data_ack=0, overwrite data and set overrun=1.
REQ-026 SHALL clear overrun only by reset.
REQ-027 SHALL hold left_data/right_data stable between commits.
REQ-028 SHALL treat data_ack with data_valid=0 as a no-op.
REQ-029 SHALL, when continuous drops mid-frame, finish that frame and then go to IDLE.

Reset
REQ-030 SHALL, with reset=1 at a posedge, force IDLE, counter 0, ADCLRC=0, busy=0, data_valid=0, overrun=0, left_data=0, right_data=0.
REQ-031 SHALL give reset priority over start, data_ack and an in-progress frame; a partial frame is discarded with no commit.
REQ-032 SHALL accept start on the first edge after reset deasserts.

Verification
REQ-033 SHALL check single frame (W=24): start 1 cycle, ADCDAT serializes L=0xA5C3F1 then R=0x12345E -> after edge E+48, left_data=0xA5C3F1, right_data=0x12345E, data_valid=1, busy=0, ADCLRC=0 in LEFT edges and 1 in RIGHT edges.
REQ-034 SHALL check handshake: data_ack pulse after frame -> data_valid=0 next edge; data unchanged; overrun=0.
REQ-035 SHALL check overrun: continuous=1, no data_ack, 2 frames L=0x000001/0x800000 -> second frame's data held, overrun=1; data_ack clears data_valid but overrun stays 1.
REQ-036 SHALL check coincidence: data_ack asserted on commit edge of frame 2 -> data_valid=1, frame-2 data, overrun=0.
REQ-037 SHALL check reset mid-frame: reset at edge E+30 -> all outputs 0 next edge; no commit; new start captures 0xFFFFFF/0x000000 correctly.
REQ-038 SHALL check start ignored while busy: start re-pulsed at E+10 -> frame completes at E+48 unchanged, busy low at E+48.

Source files
------------

// File: rtl/adc_in.sv
// Serial stereo ADC capture: shifts one left and one right word (MSB first) per frame
// and holds the last completed frame behind a valid/acknowledge handshake with sticky overrun.
module adc_in #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  BCLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  ADCDAT,
  input  logic                  data_ack,
  output logic                  ADCLRC,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [DATA_WIDTH-1:0] r_left_sr, w_left_sr_next;
  logic [DATA_WIDTH-1:0] r_right_sr, w_right_sr_next;
  logic [DATA_WIDTH-1:0] r_left_data, w_left_data_next;
  logic [DATA_WIDTH-1:0] r_right_data, w_right_data_next;
  logic                  r_valid, w_valid_next;
  logic                  r_overrun, w_overrun_next;
  logic                  r_busy, r_adclrc;
  logic                  w_commit;

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_left_sr_next    = r_left_sr;
    w_right_sr_next   = r_right_sr;
    w_left_data_next  = r_left_data;
    w_right_data_next = r_right_data;
    w_valid_next      = r_valid;
    w_overrun_next    = r_overrun;
    w_commit          = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next    = LEFT;
          w_cnt_next      = '0;
          w_left_sr_next  = '0;
          w_right_sr_next = '0;
        end
      end
      LEFT: begin
        w_left_sr_next = {r_left_sr[DATA_WIDTH-2:0], ADCDAT};
        if (r_cnt == LAST) begin
          w_state_next = RIGHT;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      RIGHT: begin
        w_right_sr_next = {r_right_sr[DATA_WIDTH-2:0], ADCDAT};
        if (r_cnt == LAST) begin
          // The bit arriving on this edge is the right LSB, so commit the shifted value.
          w_commit          = 1'b1;
          w_left_data_next  = r_left_sr;
          w_right_data_next = w_right_sr_next;
          w_state_next      = continuous ? LEFT : IDLE;
          w_cnt_next        = '0;
          w_left_sr_next    = '0;
          w_right_sr_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_commit) begin
      w_valid_next = 1'b1;
      if (r_valid && !data_ack) w_overrun_next = 1'b1;
    end else if (data_ack) begin
      w_valid_next = 1'b0;
    end
  end

  always_ff @(posedge BCLK) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_left_sr    <= '0;
      r_right_sr   <= '0;
      r_left_data  <= '0;
      r_right_data <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
      r_adclrc     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_left_sr    <= w_left_sr_next;
      r_right_sr   <= w_right_sr_next;
      r_left_data  <= w_left_data_next;
      r_right_data <= w_right_data_next;
      r_valid      <= w_valid_next;
      r_overrun    <= w_overrun_next;
      r_busy       <= (w_state_next != IDLE);
      r_adclrc     <= (w_state_next == RIGHT);
    end
  end

  assign ADCLRC     = r_adclrc;
  assign left_data  = r_left_data;
  assign right_data = r_right_data;
  assign data_valid = r_valid;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_adc_in.sv
// Bench for adc_in: directed frame scenarios plus randomized traffic, all checked every
// cycle against a bit-counting frame model.
module tb_adc_in;
  localparam int W = 24;

  logic         BCLK = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         ADCDAT = 1'b0;
  logic         data_ack = 1'b0;
  logic         ADCLRC;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         data_valid;
  logic         busy;
  logic         overrun;

  int n_checks = 0;
  int n_errors = 0;

  adc_in #(.DATA_WIDTH(W)) dut (
    .BCLK(BCLK), .reset(reset), .start(start), .continuous(continuous),
    .ADCDAT(ADCDAT), .data_ack(data_ack), .ADCLRC(ADCLRC),
    .left_data(left_data), .right_data(right_data), .data_valid(data_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 BCLK = ~BCLK;

  // Model: a frame is simply 2W consecutive bits after the start edge; -1 means no frame open.
  int           m_bits = -1;
  logic [63:0]  m_acc = '0;
  logic [W-1:0] m_left = '0, m_right = '0;
  logic         m_valid = 1'b0, m_overrun = 1'b0, m_ready = 1'b0;

  always @(posedge BCLK) begin
    if (reset) begin
      m_bits = -1; m_acc = '0; m_left = '0; m_right = '0;
      m_valid = 1'b0; m_overrun = 1'b0; m_ready = 1'b1;
    end else if (m_bits < 0) begin
      if (start) begin m_bits = 0; m_acc = '0; end
      if (data_ack) m_valid = 1'b0;
    end else begin
      m_acc  = {m_acc[62:0], ADCDAT};
      m_bits = m_bits + 1;
      if (m_bits == 2 * W) begin
        m_left  = m_acc[2*W-1 -: W];
        m_right = m_acc[W-1:0];
        if (m_valid && !data_ack) m_overrun = 1'b1;
        m_valid = 1'b1;
        m_bits  = continuous ? 0 : -1;
        m_acc   = '0;
      end else if (data_ack) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge BCLK) begin
    if (m_ready) begin
      check("model_left",    32'(left_data),  32'(m_left));
      check("model_right",   32'(right_data), 32'(m_right));
      check("model_valid",   32'(data_valid), 32'(m_valid));
      check("model_overrun", 32'(overrun),    32'(m_overrun));
      check("model_busy",    32'(busy),       32'(m_bits >= 0));
      check("model_adclrc",  32'(ADCLRC),     32'(m_bits >= W));
    end
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; data_ack = 1'b0; continuous = 1'b0;
    @(negedge BCLK); @(negedge BCLK);
    reset = 1'b0;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    @(negedge BCLK);
    start = 1'b0;
  endtask

  // Drives one frame of 2W bits; bit i is sampled on edge E+1+i.
  task automatic shift_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                             input int drop_cont_at, input int start_at, input bit ack_last);
    logic [2*W-1:0] bits;
    bits = {l, r};
    for (int i = 0; i < 2 * W; i++) begin
      ADCDAT = bits[2*W-1-i];
      if (i == drop_cont_at) continuous = 1'b0;
      start = (i == start_at);
      data_ack = ack_last && (i == 2 * W - 1);
      @(negedge BCLK);
    end
    start = 1'b0;
    data_ack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge BCLK);
    do_reset();
    check("reset_valid", 32'(data_valid), 32'd0);
    check("reset_busy",  32'(busy),       32'd0);
    check("reset_left",  32'(left_data),  32'd0);

    // Single frame.
    begin_frame();
    check("busy_after_start", 32'(busy), 32'd1);
    shift_frame(24'hA5C3F1, 24'h12345E, -1, -1, 1'b0);
    check("single_left",  32'(left_data),  32'h00A5C3F1);
    check("single_right", 32'(right_data), 32'h0012345E);
    check("single_valid", 32'(data_valid), 32'd1);
    check("single_busy",  32'(busy),       32'd0);
    check("single_lrc",   32'(ADCLRC),     32'd0);

    // Handshake.
    data_ack = 1'b1; @(negedge BCLK); data_ack = 1'b0;
    check("ack_valid",   32'(data_valid), 32'd0);
    check("ack_left",    32'(left_data),  32'h00A5C3F1);
    check("ack_overrun", 32'(overrun),    32'd0);
    data_ack = 1'b1; @(negedge BCLK); data_ack = 1'b0;
    check("ack_noop_valid", 32'(data_valid), 32'd0);

    // Overrun with two back-to-back frames; continuous dropped inside frame 2.
    continuous = 1'b1;
    begin_frame();
    shift_frame(24'h000001, 24'hABCDEF, -1, -1, 1'b0);
    check("cont_busy", 32'(busy), 32'd1);
    shift_frame(24'h800000, 24'h13579B, 10, -1, 1'b0);
    check("ovr_left",    32'(left_data),  32'h00800000);
    check("ovr_right",   32'(right_data), 32'h0013579B);
    check("ovr_overrun", 32'(overrun),    32'd1);
    check("ovr_busy",    32'(busy),       32'd0);
    data_ack = 1'b1; @(negedge BCLK); data_ack = 1'b0;
    check("ovr_ack_valid",  32'(data_valid), 32'd0);
    check("ovr_sticky",     32'(overrun),    32'd1);

    // Acknowledge coinciding with the frame-2 commit.
    do_reset();
    continuous = 1'b1;
    begin_frame();
    shift_frame(24'h0F0F0F, 24'hF0F0F0, -1, -1, 1'b0);
    shift_frame(24'h3C3C3C, 24'hC3C3C3, 5, -1, 1'b1);
    check("coin_valid",   32'(data_valid), 32'd1);
    check("coin_left",    32'(left_data),  32'h003C3C3C);
    check("coin_right",   32'(right_data), 32'h00C3C3C3);
    check("coin_overrun", 32'(overrun),    32'd0);

    // Reset on edge E+30 discards the partial frame.
    begin_frame();
    for (int i = 0; i < 29; i++) begin
      ADCDAT = 1'($urandom);
      @(negedge BCLK);
    end
    reset = 1'b1; @(negedge BCLK); reset = 1'b0;
    check("rst_mid_left",  32'(left_data),  32'd0);
    check("rst_mid_valid", 32'(data_valid), 32'd0);
    check("rst_mid_busy",  32'(busy),       32'd0);
    begin_frame();
    shift_frame(24'hFFFFFF, 24'h000000, -1, -1, 1'b0);
    check("post_rst_left",  32'(left_data),  32'h00FFFFFF);
    check("post_rst_right", 32'(right_data), 32'h00000000);

    // Start re-pulsed at E+10 is ignored.
    data_ack = 1'b1; @(negedge BCLK); data_ack = 1'b0;
    begin_frame();
    shift_frame(24'h5A5A5A, 24'h6B6B6B, -1, 9, 1'b0);
    check("ign_left",  32'(left_data),  32'h005A5A5A);
    check("ign_right", 32'(right_data), 32'h006B6B6B);
    check("ign_busy",  32'(busy),       32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      reset      = ($urandom_range(0, 799) == 0);
      start      = ($urandom_range(0, 7) == 0);
      continuous = ($urandom_range(0, 3) != 0);
      ADCDAT     = 1'($urandom);
      data_ack   = ($urandom_range(0, 39) == 0);
      @(negedge BCLK);
    end
    reset = 1'b0; start = 1'b0; data_ack = 1'b0;
    @(negedge BCLK);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
